// File: rtl/dramarb_pkg.sv
// dramarb_pkg: shared byte-select encodings and default DRAM widths for the channel arbiter
package dramarb_pkg;
  localparam logic [1:0] BSEL_LO   = 2'b01;
  localparam logic [1:0] BSEL_HI   = 2'b10;
  localparam logic [1:0] BSEL_WORD = 2'b11;
  localparam int AW_DEF = 21;
  localparam int DW_DEF = 16;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: picks one eligible channel, lowest index or rotating from ptr
module rr_pick #(
  parameter int NCH = 4,
  parameter int CW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] elig,
  input  logic [CW-1:0]  ptr,
  input  logic           rr_en,
  output logic           valid,
  output logic [CW-1:0]  win
);
  int k;
  always_comb begin
    valid = |elig;
    win   = '0;
    k     = 0;
    // scan from the farthest candidate down so the nearest eligible one wins
    for (int i = NCH - 1; i >= 0; i--) begin
      k = rr_en ? (int'(ptr) + i) % NCH : i;
      if (elig[k]) win = CW'(k);
    end
  end
endmodule

// File: rtl/dram_arb_nch.sv
// dram_arb_nch: grants one of NCH requesters per DRAM slot and routes read returns
// back to their issuers through a small owner queue
module dram_arb_nch import dramarb_pkg::*; #(
  parameter int NCH = 4,
  parameter int AW  = AW_DEF,
  parameter int DW  = DW_DEF,
  parameter int RDQ = 2
) (
  input  logic            fclk,
  input  logic            rst_n,
  input  logic            slot,
  input  logic            rr_en,
  input  logic [NCH-1:0]  ch_req,
  input  logic [NCH-1:0]  ch_rnw,
  input  logic [NCH*AW-1:0] ch_addr,
  input  logic [NCH*DW-1:0] ch_wrdata,
  input  logic [NCH*2-1:0]  ch_bsel,
  output logic [NCH-1:0]  ch_ack,
  output logic [NCH-1:0]  ch_rdstb,
  output logic [DW-1:0]   rddata,
  output logic            dram_req,
  output logic            dram_rnw,
  output logic [AW-1:0]   dram_addr,
  output logic [DW-1:0]   dram_wrdata,
  output logic [1:0]      dram_bsel,
  input  logic            dram_rrdy,
  input  logic [DW-1:0]   dram_rddata,
  output logic            err_orphan
);
  localparam int CW = $clog2(NCH);
  localparam int QW = $clog2(RDQ);
  logic [CW-1:0] ptr, win;
  logic [CW-1:0] q [RDQ];
  logic [QW-1:0] wp, rp;
  logic [QW:0]   cnt;
  logic          valid, q_full, grant, push, pop;
  logic [NCH-1:0] elig;
  assign q_full = cnt == (QW+1)'(RDQ);
  // reads wait while every owner slot is taken; writes are never held back
  assign elig   = ch_req & ~(ch_rnw & {NCH{q_full}});
  assign grant  = slot & valid;
  assign push   = grant & ch_rnw[win];
  assign pop    = dram_rrdy & (cnt != '0);
  rr_pick #(.NCH(NCH), .CW(CW)) u_pick (
    .elig(elig), .ptr(ptr), .rr_en(rr_en), .valid(valid), .win(win)
  );
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      ptr         <= '0;
      ch_ack      <= '0;
      ch_rdstb    <= '0;
      rddata      <= '0;
      dram_req    <= 1'b0;
      dram_rnw    <= 1'b0;
      dram_addr   <= '0;
      dram_wrdata <= '0;
      dram_bsel   <= '0;
      err_orphan  <= 1'b0;
      wp          <= '0;
      rp          <= '0;
      cnt         <= '0;
    end else begin
      ch_ack     <= grant ? NCH'(1) << win : '0;
      ch_rdstb   <= pop ? NCH'(1) << q[rp] : '0;
      rddata     <= pop ? dram_rddata : rddata;
      err_orphan <= err_orphan | (dram_rrdy & (cnt == '0));
      if (slot) dram_req <= valid;
      if (grant) begin
        ptr         <= (win == CW'(NCH - 1)) ? '0 : win + 1'b1;
        dram_rnw    <= ch_rnw[win];
        dram_addr   <= ch_addr[win*AW +: AW];
        dram_wrdata <= ch_wrdata[win*DW +: DW];
        dram_bsel   <= ch_bsel[win*2 +: 2];
      end
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      if (push & ~pop) cnt <= cnt + 1'b1;
      else if (pop & ~push) cnt <= cnt - 1'b1;
    end
  end
  always_ff @(posedge fclk)
    if (push) q[wp] <= win;
endmodule
